// File: rtl/sprite_draw_engine_pkg.sv
// Shared constants, FSM encoding and background address helper for the sprite draw engine.
package sprite_draw_engine_pkg;

   localparam int unsigned SCREEN_W = 320;
   localparam int unsigned SCREEN_H = 240;
   localparam int unsigned COLOUR_W = 9;

   typedef enum logic [2:0] {
      StIdle,
      StScan,
      StFlush,
      StDone,
      StRelease
   } state_e;

   // y*320 + x built from shifts so no multiplier is inferred
   function automatic logic [16:0] bg_addr(input logic [8:0] x, input logic [7:0] y);
      return ({9'd0, y} << 8) + ({9'd0, y} << 6) + {8'd0, x};
   endfunction

endpackage

// File: rtl/sprite_pixel_counter.sv
// Column/row scan counter over the sprite window with clear, enable and last-pixel flag.
module sprite_pixel_counter #(
   parameter int unsigned SPRITE_W = 8,
   parameter int unsigned SPRITE_H = 8
) (
   input  logic                        clock,
   input  logic                        resetn,
   input  logic                        clear,
   input  logic                        enable,
   output logic [$clog2(SPRITE_W)-1:0] col,
   output logic [$clog2(SPRITE_H)-1:0] row,
   output logic                        last
);

   localparam int unsigned CW = $clog2(SPRITE_W);
   localparam int unsigned RW = $clog2(SPRITE_H);

   logic col_wrap;

   assign col_wrap = (col == CW'(SPRITE_W - 1));
   assign last     = col_wrap && (row == RW'(SPRITE_H - 1));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         col <= '0;
         row <= '0;
      end else if (clear) begin
         col <= '0;
         row <= '0;
      end else if (enable) begin
         // power-of-two sizes let both counters wrap naturally
         col <= col + 1'b1;
         if (col_wrap) begin
            row <= row + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_draw_engine.sv
// Scans the sprite window and plots either background (erase) or character pixels to the VGA adapter.
module sprite_draw_engine #(
   parameter int unsigned          SPRITE_W    = 8,
   parameter int unsigned          SPRITE_H    = 8,
   parameter int unsigned          OFF_X       = 4,
   parameter int unsigned          OFF_Y       = 7,
   parameter int unsigned          COLOUR_W    = 9,
   parameter logic [COLOUR_W-1:0]  TRANSPARENT = 9'h1FF
) (
   input  logic                                 clock,
   input  logic                                 resetn,
   input  logic                                 drawBG,
   input  logic                                 drawChar,
   input  logic [8:0]                           xCoordinate,
   input  logic [7:0]                           yCoordinate,
   output logic [16:0]                          bgAddr,
   input  logic [COLOUR_W-1:0]                  bgData,
   output logic [$clog2(SPRITE_W*SPRITE_H)-1:0] charAddr,
   input  logic [COLOUR_W-1:0]                  charData,
   output logic [8:0]                           vgaX,
   output logic [7:0]                           vgaY,
   output logic [COLOUR_W-1:0]                  colour,
   output logic                                 plot,
   output logic                                 doneBG,
   output logic                                 doneChar
);

   import sprite_draw_engine_pkg::*;

   localparam int unsigned CW = $clog2(SPRITE_W);
   localparam int unsigned RW = $clog2(SPRITE_H);

   state_e         state_q, state_d;
   logic [8:0]     x_q;
   logic [7:0]     y_q;
   logic           bg_q;
   logic           latch, cnt_clr, cnt_en, last;
   logic [CW-1:0]  col;
   logic [RW-1:0]  row;
   logic [9:0]     sx;
   logic [8:0]     sy;
   logic           on_screen;
   logic           pix_valid_q;
   logic [8:0]     vgax_q;
   logic [7:0]     vgay_q;

   sprite_pixel_counter #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H)
   ) u_counter (
      .clock  (clock),
      .resetn (resetn),
      .clear  (cnt_clr),
      .enable (cnt_en),
      .col    (col),
      .row    (row),
      .last   (last)
   );

   always_comb begin
      state_d = state_q;
      latch   = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (drawBG || drawChar) begin
               latch   = 1'b1;
               cnt_clr = 1'b1;
               state_d = StScan;
            end
         end
         StScan: begin
            cnt_en = 1'b1;
            if (last) state_d = StFlush;
         end
         StFlush:   state_d = StDone;
         StDone:    state_d = StRelease;
         StRelease: begin
            // wait for the request that started this draw to drop
            if (bg_q ? !drawBG : !drawChar) state_d = StIdle;
         end
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         x_q     <= '0;
         y_q     <= '0;
         bg_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (latch) begin
            x_q  <= xCoordinate;
            y_q  <= yCoordinate;
            bg_q <= drawBG;
         end
      end
   end

   // signed window coordinates; sign bit flags pixels left of / above the screen
   assign sx        = 10'(x_q) - 10'(OFF_X) + 10'(col);
   assign sy        = 9'(y_q) - 9'(OFF_Y) + 9'(row);
   assign on_screen = !sx[9] && (sx < 10'(SCREEN_W)) && !sy[8] && (sy < 9'(SCREEN_H));

   assign bgAddr   = (state_q == StScan && on_screen) ? bg_addr(sx[8:0], sy[7:0]) : '0;
   assign charAddr = (state_q == StScan) ? {row, col} : '0;

   // delay the pixel coordinate one cycle to line up with ROM read data
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pix_valid_q <= 1'b0;
         vgax_q      <= '0;
         vgay_q      <= '0;
      end else begin
         pix_valid_q <= (state_q == StScan) && on_screen;
         if (state_q == StScan) begin
            vgax_q <= sx[8:0];
            vgay_q <= sy[7:0];
         end
      end
   end

   assign vgaX     = vgax_q;
   assign vgaY     = vgay_q;
   assign plot     = pix_valid_q && (bg_q || (charData != TRANSPARENT));
   assign colour   = pix_valid_q ? (bg_q ? bgData : charData) : '0;
   assign doneBG   = (state_q == StDone) && bg_q;
   assign doneChar = (state_q == StDone) && !bg_q;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Scoreboard bench: driver queues expected plots/done pulses, negedge monitor pops and compares.
module tb_sprite_draw_engine;

   logic       clock = 1'b0;
   logic       resetn;
   logic       drawBG, drawChar;
   logic [8:0] xCoordinate;
   logic [7:0] yCoordinate;
   logic [16:0] bgAddr;
   logic [8:0] bgData, charData, colour;
   logic [5:0] charAddr;
   logic [8:0] vgaX;
   logic [7:0] vgaY;
   logic       plot, doneBG, doneChar;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {int cyc; int x; int y; int col;} plot_t;
   typedef struct {int cyc; bit bg;} done_t;
   typedef struct {int cyc; bit is_bg; int val;} addr_t;

   plot_t pq[$];
   done_t dq[$];
   addr_t aq[$];

   sprite_draw_engine dut (
      .clock       (clock),
      .resetn      (resetn),
      .drawBG      (drawBG),
      .drawChar    (drawChar),
      .xCoordinate (xCoordinate),
      .yCoordinate (yCoordinate),
      .bgAddr      (bgAddr),
      .bgData      (bgData),
      .charAddr    (charAddr),
      .charData    (charData),
      .vgaX        (vgaX),
      .vgaY        (vgaY),
      .colour      (colour),
      .plot        (plot),
      .doneBG      (doneBG),
      .doneChar    (doneChar)
   );

   always #5 clock = ~clock;

   function automatic logic [8:0] bg_rom(input logic [16:0] a);
      return a[8:0] ^ {1'b0, a[16:9]};
   endfunction

   // transparent at even columns
   function automatic logic [8:0] chr_rom(input logic [5:0] a);
      return a[0] ? {3'b101, a} : 9'h1FF;
   endfunction

   always @(posedge clock) begin
      cyc      <= cyc + 1;
      bgData   <= bg_rom(bgAddr);
      charData <= chr_rom(charAddr);
   end

   always @(negedge clock) begin
      if (aq.size() > 0 && aq[0].cyc == cyc) begin
         addr_t a;
         int got;
         a = aq.pop_front();
         got = a.is_bg ? int'(bgAddr) : int'(charAddr);
         checks++;
         if (got != a.val) begin
            failures++;
            $display("FAIL addr cyc=%0d bg=%0b got=%0d want=%0d", cyc, a.is_bg, got, a.val);
         end
      end
      if (plot) begin
         checks++;
         if (pq.size() == 0) begin
            failures++;
            $display("FAIL plot_unexpected cyc=%0d got x=%0d y=%0d c=%h want none",
                     cyc, vgaX, vgaY, colour);
         end else begin
            plot_t p;
            p = pq.pop_front();
            if (p.cyc != cyc || p.x != int'(vgaX) || p.y != int'(vgaY) || p.col != int'(colour)) begin
               failures++;
               $display("FAIL plot got cyc=%0d x=%0d y=%0d c=%h want cyc=%0d x=%0d y=%0d c=%h",
                        cyc, vgaX, vgaY, colour, p.cyc, p.x, p.y, p.col);
            end
         end
      end
      if (doneBG || doneChar) begin
         checks++;
         if (dq.size() == 0) begin
            failures++;
            $display("FAIL done_unexpected cyc=%0d got bg=%0b ch=%0b want none",
                     cyc, doneBG, doneChar);
         end else begin
            done_t d;
            d = dq.pop_front();
            if (d.cyc != cyc || doneBG != d.bg || doneChar != !d.bg) begin
               failures++;
               $display("FAIL done got cyc=%0d bg=%0b ch=%0b want cyc=%0d bg=%0b ch=%0b",
                        cyc, doneBG, doneChar, d.cyc, d.bg, !d.bg);
            end
         end
      end
   end

   // Expected plots for the first npix pixels of a scan whose request is sampled at cyc t0
   task automatic push_scan(input bit bg, input int x, input int y, input int t0, input int npix);
      for (int k = 0; k < npix; k++) begin
         int c, r, sx, sy, colv;
         c  = k % 8;
         r  = k / 8;
         sx = x - 4 + c;
         sy = y - 7 + r;
         if (sx >= 0 && sx < 320 && sy >= 0 && sy < 240) begin
            if (bg) colv = int'(bg_rom(17'(sy * 320 + sx)));
            else    colv = int'(chr_rom(6'(r * 8 + c)));
            if (bg || colv != 9'h1FF) pq.push_back('{cyc: t0 + 1 + k, x: sx, y: sy, col: colv});
            if (bg && k == 0) aq.push_back('{cyc: t0, is_bg: 1'b1, val: sy * 320 + sx});
         end
      end
      if (!bg && npix > 9) aq.push_back('{cyc: t0 + 9, is_bg: 1'b0, val: 9});
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (pq.size() != 0 || dq.size() != 0 || aq.size() != 0) begin
         failures++;
         $display("FAIL drain_%s got pending plots=%0d dones=%0d addrs=%0d want 0/0/0",
                  name, pq.size(), dq.size(), aq.size());
         pq.delete();
         dq.delete();
         aq.delete();
      end
   endtask

   task automatic run_req(input string name, input bit bg, input bit ch, input int x,
                          input int y, input int hold);
      int t0;
      @(negedge clock);
      drawBG      = bg;
      drawChar    = ch;
      xCoordinate = 9'(x);
      yCoordinate = 8'(y);
      t0 = cyc + 1;
      push_scan(bg, x, y, t0, 64);
      dq.push_back('{cyc: t0 + 65, bg: bg});
      repeat (10) @(negedge clock);
      // coordinate changes after the latch must not disturb the scan
      xCoordinate = 9'd7;
      yCoordinate = 8'd9;
      repeat (56 + hold) @(negedge clock);
      drawBG   = 1'b0;
      drawChar = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      check_drained(name);
   endtask

   initial begin
      int t0;
      resetn      = 1'b0;
      drawBG      = 1'b0;
      drawChar    = 1'b0;
      xCoordinate = '0;
      yCoordinate = '0;
      #12;
      checks++;
      if (plot || doneBG || doneChar || bgAddr != 0 || charAddr != 0 || vgaX != 0 ||
          vgaY != 0 || colour != 0) begin
         failures++;
         $display("FAIL reset_state got plot=%0b dbg=%0b dch=%0b ba=%0d ca=%0d x=%0d y=%0d c=%h want all 0",
                  plot, doneBG, doneChar, bgAddr, charAddr, vgaX, vgaY, colour);
      end
      @(negedge clock);
      resetn = 1'b1;
      repeat (2) @(negedge clock);

      run_req("bg_96_222", 1'b1, 1'b0, 96, 222, 10);
      run_req("char_even_transparent", 1'b0, 1'b1, 50, 50, 0);
      run_req("bg_top_left_clip", 1'b1, 1'b0, 2, 3, 0);
      run_req("both_high_hold", 1'b1, 1'b1, 160, 120, 20);

      // reset while pixel 20 is being issued: pixels 0..18 have been plotted
      @(negedge clock);
      drawBG      = 1'b1;
      xCoordinate = 9'd100;
      yCoordinate = 8'd100;
      t0 = cyc + 1;
      push_scan(1'b1, 100, 100, t0, 19);
      repeat (21) @(posedge clock);
      #2;
      resetn = 1'b0;
      drawBG = 1'b0;
      #1;
      checks++;
      if (plot || doneBG) begin
         failures++;
         $display("FAIL reset_mid_scan got plot=%0b doneBG=%0b want 0 0", plot, doneBG);
      end
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      check_drained("reset_abort");
      run_req("bg_after_reset", 1'b1, 1'b0, 200, 100, 0);

      // move: erase at old anchor, then draw one pixel down-right
      run_req("move_bg", 1'b1, 1'b0, 100, 100, 0);
      run_req("move_char", 1'b0, 1'b1, 101, 101, 0);
      run_req("char_bottom_right_clip", 1'b0, 1'b1, 318, 236, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sprite_draw_engine.md
# sprite_draw_engine

Downstream stage of the movement FSM: consumes the `drawBG` / `drawChar` requests and the 9-bit/8-bit character anchor coordinate, scans a SPRITE_W × SPRITE_H window pixel by pixel, and emits plot writes to the VGA adapter. For each write it reads either the background ROM (erasing the old sprite) or the character ROM (drawing the new one). It returns `doneBG` / `doneChar` to the movement FSM.

## Interface
- SPRITE_W, 8, sprite width in pixels (power of two)
- SPRITE_H, 8, sprite height in pixels (power of two)
- OFF_X, 4, anchor-to-left-edge offset; window left column = X − OFF_X
- OFF_Y, 7, anchor-to-top-edge offset; window top row = Y − OFF_Y
- COLOUR_W, 9, colour bits (3 per channel)
- TRANSPARENT, 9'h1FF, character ROM value that is not plotted
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- drawBG  in  1  level request: redraw background over the window
- drawChar  in  1  level request: draw character over the window
- xCoordinate  in  9  anchor X (0..319)
- yCoordinate  in  8  anchor Y (0..239)
- bgAddr  out  17  background ROM address, y*320+x
- bgData  in  COLOUR_W  background ROM data, 1-cycle synchronous read
- charAddr  out  log2(W*H)  character ROM address, row*SPRITE_W+col
- charData  in  COLOUR_W  character ROM data, 1-cycle synchronous read
- vgaX  out  9  plot X
- vgaY  out  8  plot Y
- colour  out  COLOUR_W  plot colour
- plot  out  1  write strobe to VGA adapter
- doneBG  out  1  one-cycle pulse: background redraw complete
- doneChar  out  1  one-cycle pulse: character draw complete

## Operation
- States: IDLE, SCAN, FLUSH, DONE, RELEASE.
- IDLE: on a clock edge with `drawBG` or `drawChar` high:
  - latch xCoordinate, yCoordinate and mode; if both are high, BG wins
  - clear col/row counters; go to SCAN
- SCAN: each cycle, issue an address for pixel (col,row) and advance col.
  - When col wraps, advance row.
  - After pixel (W−1,H−1) is issued, go to FLUSH.
- FLUSH: the last ROM datum returns and is plotted; go to DONE.
- DONE: pulse doneBG or doneChar (per latched mode) for exactly one cycle; go to RELEASE.
- RELEASE: stay until the latched request input is low, then go to IDLE. This prevents a re-trigger from a held request.
- Pixel screen coordinate: sx = X − OFF_X + col, sy = Y − OFF_Y + row.
  - Compute in 10/9-bit signed arithmetic.
  - Off-screen pixels (sx<0, sx>319, sy<0, sy>239) are never plotted; the scan still spends a cycle on them.
  - bgAddr for an off-screen pixel is don't-care.
- bgAddr = (sy<<8)+(sy<<6)+sx, 17 bits, no overflow for on-screen pixels.
- Char mode: plot is suppressed when charData == TRANSPARENT. BG mode plots every on-screen pixel.
- xCoordinate/yCoordinate changes after the latch are ignored until the next IDLE.
- A request arriving in SCAN/FLUSH/DONE is ignored (the movement FSM never issues one).

## Timing
- Reset (async, any state) → IDLE; all outputs 0; counters 0; an in-progress draw is abandoned with no done pulse.
- Request sampled at edge t → SCAN cycles t+1 … t+W·H.
- Pixel k address is issued in cycle t+1+k.
- vgaX/vgaY/colour/plot for pixel k are valid in cycle t+2+k (registered, aligned with ROM data).
- FLUSH = cycle t+1+W·H; done pulse in cycle t+2+W·H. For 8×8: done at t+66.
- plot is never high outside SCAN/FLUSH; its last assertion is the FLUSH cycle.
- doneBG and doneChar are mutually exclusive and never high in consecutive cycles.

## Structure
- Shared package: SCREEN_W=320, SCREEN_H=240, COLOUR_W, state encoding, BG address function.
- One sub-module: `sprite_pixel_counter` (col/row counters, wrap, `last` flag, clear/enable).
- Engine holds the FSM, coordinate latch, address arithmetic, clip and transparency logic, and output registers.

## Test plan
- Reset mid-SCAN (resetn low at pixel 20) → plot=0, doneBG=0 immediately; returns to IDLE; next request runs a full 64-pixel scan.
- drawBG held at X=96, Y=222 → 64 plots covering x 92..99, y 215..222; bgAddr of first pixel = 215·320+92 = 68892; doneBG single pulse at t+66.
- drawChar with ROM containing TRANSPARENT at even cols → exactly 32 plots; doneChar at t+66; doneBG stays 0.
- Anchor X=2, Y=3 (window straddles top-left) → only pixels with sx≥0, sy≥0 plotted (6 cols × 4 rows = 24 writes); done timing unchanged.
- drawBG and drawChar both high → BG mode; doneBG pulses; held request produces no second scan until dropped.
- Full move cycle with the movement FSM (BG, update, char) → BG done precedes char start; the sprite moves one pixel diagonally with no residue.
